// File: rtl/signed_division_if.sv
// Handshake and operand/result bundle for the sign-magnitude divider.
//   master: drives start and operands, receives results and status
//   slave : the divider itself
interface signed_division_if #(
  parameter int unsigned W = 15,
  parameter int unsigned D = 4
);
  logic         start;
  logic [W-1:0] dvd_mag;
  logic         dvd_s;
  logic [D-1:0] dvs_mag;
  logic         dvs_s;
  logic [W-1:0] quo_mag;
  logic         quo_s;
  logic [D-1:0] rem_mag;
  logic         rem_s;
  logic         busy;
  logic         done;
  logic         div0;

  modport master (
    output start, dvd_mag, dvd_s, dvs_mag, dvs_s,
    input  quo_mag, quo_s, rem_mag, rem_s, busy, done, div0
  );

  modport slave (
    input  start, dvd_mag, dvd_s, dvs_mag, dvs_s,
    output quo_mag, quo_s, rem_mag, rem_s, busy, done, div0
  );
endinterface

// File: rtl/signed_division.sv
// Sequential sign-magnitude restoring divider, one quotient bit per clock.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : start/operands in; quo/rem (sign-magnitude), busy, done, div0 out
// A request is accepted only in IDLE; W RUN steps follow, then a one-cycle
// DONE where results become valid and are held until the next DONE.
module signed_division #(
  parameter int unsigned W = 15,
  parameter int unsigned D = 4
) (
  input  logic              clk,
  input  logic              rst,
  signed_division_if.slave  bus
);

  localparam int unsigned CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q;
  state_t        state_n;
  logic [CW-1:0] cnt_q;
  logic [D:0]    pr_q;
  logic [W-1:0]  dvd_q;
  logic [D-1:0]  dvs_q;
  logic          dvd_s_q;
  logic          dvs_s_q;

  logic [D:0]    pr_sh;
  logic [D:0]    pr_nx;
  logic          qbit;
  logic [W-1:0]  quo_nx;
  logic          last_step;

  // One restoring step; dvd_q shifts out dividend bits and shifts in quotient bits.
  always_comb begin
    pr_sh     = (pr_q << 1) | {{D{1'b0}}, dvd_q[W-1]};
    qbit      = (pr_sh >= {1'b0, dvs_q});
    pr_nx     = qbit ? (pr_sh - {1'b0, dvs_q}) : pr_sh;
    quo_nx    = {dvd_q[W-2:0], qbit};
    last_step = (cnt_q == '0);
  end

  // Next-state logic
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_n = RUN;
      RUN:     if (last_step) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      pr_q        <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      dvd_s_q     <= 1'b0;
      dvs_s_q     <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.quo_mag <= '0;
      bus.quo_s   <= 1'b0;
      bus.rem_mag <= '0;
      bus.rem_s   <= 1'b0;
      bus.div0    <= 1'b0;
    end else begin
      bus.busy <= (state_n != IDLE);
      bus.done <= (state_n == DONE);
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            dvd_q   <= bus.dvd_mag;
            dvd_s_q <= bus.dvd_s;
            dvs_q   <= bus.dvs_mag;
            dvs_s_q <= bus.dvs_s;
            cnt_q   <= CW'(W - 1);
            pr_q    <= '0;
          end
        end
        RUN: begin
          pr_q  <= pr_nx;
          dvd_q <= quo_nx;
          cnt_q <= cnt_q - CW'(1);
          if (last_step) begin
            if (dvs_q == '0) begin
              // Divide-by-zero still runs all steps; result is a fixed marker.
              bus.quo_mag <= '1;
              bus.quo_s   <= 1'b0;
              bus.rem_mag <= '0;
              bus.rem_s   <= 1'b0;
              bus.div0    <= 1'b1;
            end else begin
              // Signs are suppressed on zero magnitudes: no negative zero.
              bus.quo_mag <= quo_nx;
              bus.quo_s   <= (dvd_s_q ^ dvs_s_q) & (|quo_nx);
              bus.rem_mag <= pr_nx[D-1:0];
              bus.rem_s   <= dvd_s_q & (|pr_nx[D-1:0]);
              bus.div0    <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_division.sv
// Scoreboard bench for signed_division: stimulus pushes expected results,
// a negedge monitor pops and compares whenever done is high.
module tb_signed_division;

  localparam int unsigned W = 15;
  localparam int unsigned D = 4;

  typedef struct {
    logic [W-1:0] qm;
    logic         qs;
    logic [D-1:0] rm;
    logic         rs;
    logic         d0;
    int unsigned  edge_n;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic         as;
    logic [D-1:0] b;
    logic         bs;
    logic [W-1:0] qm;
    logic         qs;
    logic [D-1:0] rm;
    logic         rs;
    logic         d0;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  signed_division_if #(.W(W), .D(D)) bus ();

  signed_division #(.W(W), .D(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        sb[$];
  exp_t        hold;
  exp_t        e;
  vec_t        vecs[8];
  int          tests = 0;
  int          fails = 0;
  int unsigned edge_cnt = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, edge_cnt);
    end
  endtask

  function automatic logic [31:0] pack_out();
    return 32'({bus.quo_mag, bus.quo_s, bus.rem_mag, bus.rem_s, bus.div0});
  endfunction

  function automatic logic [31:0] pack_exp(input exp_t x);
    return 32'({x.qm, x.qs, x.rm, x.rs, x.d0});
  endfunction

  // Monitor: compare on done, otherwise results must hold their last value.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(bus.done), 32'(0));
        end else begin
          e = sb.pop_front();
          check("quo_mag",   32'(bus.quo_mag), 32'(e.qm));
          check("quo_s",     32'(bus.quo_s),   32'(e.qs));
          check("rem_mag",   32'(bus.rem_mag), 32'(e.rm));
          check("rem_s",     32'(bus.rem_s),   32'(e.rs));
          check("div0",      32'(bus.div0),    32'(e.d0));
          check("done_edge", edge_cnt,         e.edge_n);
          check("busy_done", 32'(bus.busy),    32'(1));
          hold = e;
        end
      end else begin
        check("result_hold", pack_out(), pack_exp(hold));
      end
    end
  end

  // Called in the low phase; start is sampled on the next edge.
  task automatic issue(input vec_t v, input bit push);
    exp_t x;
    bus.start   = 1'b1;
    bus.dvd_mag = v.a;
    bus.dvd_s   = v.as;
    bus.dvs_mag = v.b;
    bus.dvs_s   = v.bs;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.dvd_mag = W'($urandom);
    bus.dvd_s   = 1'($urandom);
    bus.dvs_mag = D'($urandom);
    bus.dvs_s   = 1'($urandom);
    if (push) begin
      x.qm = v.qm; x.qs = v.qs; x.rm = v.rm; x.rs = v.rs; x.d0 = v.d0;
      x.edge_n = edge_cnt + W;
      sb.push_back(x);
    end
  endtask

  // Wait until the scoreboard drains, then step into the following IDLE cycle.
  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    check("drain", 32'(sb.size()), 32'(0));
    @(negedge clk);
  endtask

  vec_t v;

  initial begin
    vecs[0] = '{15'd32767, 1'b0, 4'd15, 1'b1, 15'd2184,  1'b1, 4'd7, 1'b0, 1'b0};
    vecs[1] = '{15'd3,     1'b1, 4'd7,  1'b1, 15'd0,     1'b0, 4'd3, 1'b1, 1'b0};
    vecs[2] = '{15'd14,    1'b1, 4'd7,  1'b0, 15'd2,     1'b1, 4'd0, 1'b0, 1'b0};
    vecs[3] = '{15'd5,     1'b0, 4'd0,  1'b0, 15'h7FFF,  1'b0, 4'd0, 1'b0, 1'b1};
    vecs[4] = '{15'd9,     1'b0, 4'd3,  1'b0, 15'd3,     1'b0, 4'd0, 1'b0, 1'b0};
    vecs[5] = '{15'd0,     1'b1, 4'd5,  1'b0, 15'd0,     1'b0, 4'd0, 1'b0, 1'b0};
    vecs[6] = '{15'd7,     1'b0, 4'd15, 1'b1, 15'd0,     1'b0, 4'd7, 1'b0, 1'b0};
    vecs[7] = '{15'd32767, 1'b1, 4'd1,  1'b0, 15'd32767, 1'b1, 4'd0, 1'b0, 1'b0};

    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.dvd_mag = '0;
    bus.dvd_s   = 1'b0;
    bus.dvs_mag = '0;
    bus.dvs_s   = 1'b0;
    hold        = '{'0, 1'b0, '0, 1'b0, 1'b0, 0};
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    check("reset_busy", 32'(bus.busy), 32'(0));
    check("reset_done", 32'(bus.done), 32'(0));
    check("reset_outs", pack_out(),    32'(0));
    rst = 1'b0;
    @(negedge clk);

    // +100 / +7 with busy/done timing traced cycle by cycle
    v = '{15'd100, 1'b0, 4'd7, 1'b0, 15'd14, 1'b0, 4'd2, 1'b0, 1'b0};
    issue(v, 1'b1);
    check("busy_start", 32'(bus.busy), 32'(1));
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      check("busy_run", 32'(bus.busy), 32'(1));
      check("done_time", 32'(bus.done), 32'(i == 15));
    end
    @(negedge clk);
    check("busy_idle", 32'(bus.busy), 32'(0));
    check("done_low",  32'(bus.done), 32'(0));

    // -100 / +7 issued back-to-back in the IDLE cycle
    v = '{15'd100, 1'b1, 4'd7, 1'b0, 15'd14, 1'b1, 4'd2, 1'b1, 1'b0};
    issue(v, 1'b1);
    wait_idle();

    for (int k = 0; k < 8; k++) begin
      issue(vecs[k], 1'b1);
      wait_idle();
    end

    // Starts during RUN and DONE are ignored; a start in IDLE is accepted.
    v = '{15'd1000, 1'b0, 4'd3, 1'b0, 15'd333, 1'b0, 4'd1, 1'b0, 1'b0};
    issue(v, 1'b1);
    repeat (5) @(negedge clk);
    bus.start = 1'b1; bus.dvd_mag = 15'd50; bus.dvs_mag = 4'd5; bus.dvd_s = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("done_cycle", 32'(bus.done), 32'(1));
    bus.start = 1'b1; bus.dvd_mag = 15'd77; bus.dvs_mag = 4'd2; bus.dvs_s = 1'b1;
    @(negedge clk);
    check("idle_after", 32'(bus.busy), 32'(0));
    v = '{15'd200, 1'b0, 4'd9, 1'b0, 15'd22, 1'b0, 4'd2, 1'b0, 1'b0};
    issue(v, 1'b1);
    wait_idle();

    // Reset mid-run discards the division.
    v = '{15'd500, 1'b0, 4'd4, 1'b0, 15'd125, 1'b0, 4'd0, 1'b0, 1'b0};
    issue(v, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    hold = '{'0, 1'b0, '0, 1'b0, 1'b0, 0};
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_outs", pack_out(),    32'(0));
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("rst_stay_idle", 32'(bus.busy), 32'(0));

    // Recovery after reset
    issue(vecs[4], 1'b1);
    wait_idle();

    check("sb_empty", 32'(sb.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
